imm_ext_pipe: RTL
=================

Name: imm_ext_pipe

Overview:
- Pipelined, parametrised immediate extender/shifter for the decode stage.
- Accepts an IN_W-bit immediate plus a 3-bit mode, forms an OUT_W-bit operand, and returns it through a registered valid/ready output.
- Output is buffered by a 2-entry skid buffer, so upstream decode never sees combinational ready paths from execute.
- Supports zero-extend, sign-extend, shifted branch offsets, upper-immediate (LUI) and a pass-through mode.

Parameters:
- IN_W, 16, immediate input width (>=2).
- OUT_W, 32, output width (> IN_W + SHAMT).
- SHAMT, 2, left-shift amount for the branch/jump offset modes.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input immediate/mode valid.
- in_ready  out  1  block can accept an input this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  3  extension mode (encoding below).
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_W  extended/shifted result.
- out_err  out  1  illegal mode flag travelling with out_data.

Behaviour:
- One clock; reset is asynchronous and active-high. While rst is high: out_valid=0, out_data=0, out_err=0, in_ready=0, skid buffer empty. First cycle after release: in_ready=1.
- Mode encoding:
  - 000 ZE: zero-extend in_imm.
  - 001 SE: sign-extend from in_imm[IN_W-1].
  - 010 ZE_SHL: ZE, then left shift by SHAMT.
  - 011 SE_SHL: SE, then left shift by SHAMT (branch offset).
  - 100 UPPER: in_imm in bits [OUT_W-1 : OUT_W-IN_W], zeros below.
  - 101 PASS_LO: ZE with bit 0 forced to 0 (jump-register alignment).
  - 110/111: illegal.
- Shifts discard bits shifted beyond OUT_W-1; bits shifted in are zero.
- Transfer rules: input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
- Latency: a result computed from an accepted input appears on out_data the next cycle (1-cycle latency) when the buffer was empty.
- Skid buffer, 2 entries: main register drives the outputs; the skid register captures data when out_ready drops.
- in_ready = registered "skid empty", never a combinational function of out_ready.
- FSM states:
  - EMPTY → ONE on input accept.
  - ONE → EMPTY on output accept with no input.
  - ONE → ONE on simultaneous input and output accept (pass-through, no bubble).
  - ONE → FULL on input accept with no output accept.
  - FULL → ONE on output accept; skid moves into main; in_ready goes high the following cycle.
  - FULL: in_ready=0, so an input offer is ignored.
- Ordering is strictly FIFO; no data is dropped or duplicated.
- out_data and out_err hold stable while out_valid && !out_ready.
- Reset mid-operation clears both entries; in-flight data is discarded.

Optional Feature:
- Macro IMM_EXT_ERR_EN.
- When defined:
  - Illegal modes (110/111) produce out_data=0 and out_err=1 for that beat.
  - out_err is registered alongside the data.
- When undefined:
  - Illegal modes decode as ZE.
  - out_err is tied to 0.
  - No error storage flops are built.

Decomposition:
- Shared package imm_ext_pkg:
  - mode enum/localparams (MODE_ZE, MODE_SE, MODE_ZE_SHL, MODE_SE_SHL, MODE_UPPER, MODE_PASS_LO).
  - skid FSM state encoding (ST_EMPTY, ST_ONE, ST_FULL).
- Sub-module imm_ext_core: purely combinational mode decode and extension, parametrised by IN_W/OUT_W/SHAMT, instantiated once ahead of the skid buffer.

Test Plan:
- Mode sweep, defaults, out_ready=1, in_imm=16'h8001 → the next-cycle out_data for each mode is:
  - ZE: 32'h00008001.
  - SE: 32'hFFFF8001.
  - ZE_SHL: 32'h00020004.
  - SE_SHL: 32'hFFFE0004.
  - UPPER: 32'h80010000.
  - PASS_LO: 32'h00008000.
- Back-pressure: send 3 back-to-back SE inputs (16'h0001, 16'hFFFF, 16'h7FFF) with out_ready=0 → in_ready drops after the second accept, out_data holds 32'h00000001; release out_ready → values emerge in order: 32'h00000001, 32'hFFFFFFFF, 32'h00007FFF.
- Streaming: in_valid=1 and out_ready=1 continuously for 8 beats → one result per cycle, no bubbles, in_ready stays 1.
- Async reset: assert rst mid-cycle while FULL → out_valid and in_ready drop immediately without a clock edge; after release, no stale data appears.
- Illegal mode: in_mode=3'b110 with in_imm=16'h1234 → with IMM_EXT_ERR_EN: out_data=0, out_err=1; without it: out_data=32'h00001234, out_err=0.
- Parameter variant IN_W=12, OUT_W=64, SHAMT=1, SE_SHL, in_imm=12'h800 → out_data=64'hFFFFFFFFFFFFF000.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate extender pipeline: extension modes and skid FSM states.
package imm_ext_pkg;

   typedef enum logic [2:0] {
      MODE_ZE      = 3'b000,
      MODE_SE      = 3'b001,
      MODE_ZE_SHL  = 3'b010,
      MODE_SE_SHL  = 3'b011,
      MODE_UPPER   = 3'b100,
      MODE_PASS_LO = 3'b101
   } mode_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational mode decode and immediate extension/shift.
// With IMM_EXT_ERR_EN defined, illegal modes give zero data plus an error flag; otherwise they decode as ZE.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHAMT = 2
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [2:0]       mode,
   output logic [OUT_W-1:0] data
`ifdef IMM_EXT_ERR_EN
   ,
   output logic             err
`endif
);

   logic [OUT_W-1:0] ze_s;
   logic [OUT_W-1:0] se_s;

   assign ze_s = {{(OUT_W-IN_W){1'b0}}, imm};
   assign se_s = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   // Select the extended operand for the requested mode.
   always_comb begin
      data = ze_s;
`ifdef IMM_EXT_ERR_EN
      err  = 1'b0;
`endif
      case (mode_e'(mode))
         MODE_ZE:      data = ze_s;
         MODE_SE:      data = se_s;
         MODE_ZE_SHL:  data = ze_s << SHAMT;
         MODE_SE_SHL:  data = se_s << SHAMT;
         MODE_UPPER:   data = {imm, {(OUT_W-IN_W){1'b0}}};
         MODE_PASS_LO: data = {ze_s[OUT_W-1:1], 1'b0};
         default: begin
`ifdef IMM_EXT_ERR_EN
            data = {OUT_W{1'b0}};
            err  = 1'b1;
`else
            data = ze_s;
`endif
         end
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: combinational core followed by a 2-entry skid buffer.
// Optional IMM_EXT_ERR_EN carries an illegal-mode flag alongside each result.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHAMT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err
);

   state_e           state_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [OUT_W-1:0] main_data_r;
   logic [OUT_W-1:0] skid_data_r;
   logic [OUT_W-1:0] core_data_s;
   logic             in_acc_s;
   logic             out_acc_s;
   logic             load_main_core_s;
   logic             load_main_skid_s;
   logic             load_skid_s;

`ifdef IMM_EXT_ERR_EN
   logic             core_err_s;
   logic             main_err_r;
   logic             skid_err_r;
`endif

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHAMT (SHAMT)
   ) u_core (
      .imm  (in_imm),
      .mode (in_mode),
      .data (core_data_s)
`ifdef IMM_EXT_ERR_EN
      ,
      .err  (core_err_s)
`endif
   );

   assign in_acc_s  = in_valid && in_ready_r;
   assign out_acc_s = out_valid_r && out_ready;

   // A new result bypasses the skid register whenever the main slot is free or draining.
   assign load_main_core_s = in_acc_s && ((state_r == ST_EMPTY) || ((state_r == ST_ONE) && out_acc_s));
   assign load_skid_s      = in_acc_s && (state_r == ST_ONE) && !out_acc_s;
   assign load_main_skid_s = (state_r == ST_FULL) && out_acc_s;

   // Skid FSM with registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               in_ready_r <= 1'b1;
               if (in_acc_s) begin
                  state_r     <= ST_ONE;
                  out_valid_r <= 1'b1;
               end
            end
            ST_ONE: begin
               if (in_acc_s && !out_acc_s) begin
                  state_r    <= ST_FULL;
                  in_ready_r <= 1'b0;
               end else if (!in_acc_s && out_acc_s) begin
                  state_r     <= ST_EMPTY;
                  out_valid_r <= 1'b0;
               end
            end
            ST_FULL: begin
               if (out_acc_s) begin
                  state_r    <= ST_ONE;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_EMPTY;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Main and skid data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data_r <= {OUT_W{1'b0}};
         skid_data_r <= {OUT_W{1'b0}};
      end else begin
         if (load_main_core_s) begin
            main_data_r <= core_data_s;
         end else if (load_main_skid_s) begin
            main_data_r <= skid_data_r;
         end
         if (load_skid_s) begin
            skid_data_r <= core_data_s;
         end
      end
   end

`ifdef IMM_EXT_ERR_EN
   // Error flags follow exactly the same moves as the data they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_err_r <= 1'b0;
         skid_err_r <= 1'b0;
      end else begin
         if (load_main_core_s) begin
            main_err_r <= core_err_s;
         end else if (load_main_skid_s) begin
            main_err_r <= skid_err_r;
         end
         if (load_skid_s) begin
            skid_err_r <= core_err_s;
         end
      end
   end

   assign out_err = main_err_r;
`else
   assign out_err = 1'b0;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = main_data_r;

endmodule
